lgn_image_streamer: RTL and testbench

Host-side driver for the LGN MNIST classifier's 8-bit pixel input and 8-bit result output. It holds one binarized 28×28 image in a local buffer. On a start request it streams the image as 98 bytes, one byte per cycle. It then waits a fixed latency, captures the predicted class from the classifier output and reports it with a one-cycle valid pulse. It sits on the FPGA top level between a host/loader and the classifier instance.

---
 rtl/lgn_streamer_pkg.sv | 22 ++
 rtl/lgn_image_buffer.sv | 34 +++
 rtl/lgn_image_streamer.sv | 162 ++++++++++++++++
 tb/tb_lgn_image_streamer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lgn_streamer_pkg.sv
// lgn_streamer_pkg: shared constants, FSM state encoding and a class-range
// helper for the LGN MNIST image streamer.
package lgn_streamer_pkg;

    localparam int IMG_W       = 28;
    localparam int IMG_BYTES   = 98;
    localparam int NUM_CLASSES = 10;
    localparam int ADDR_W      = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } stream_state_t;

    // True when the classifier reports an index outside 0..NUM_CLASSES-1.
    function automatic logic is_bad_class(input logic [3:0] cls);
        return cls > 4'(NUM_CLASSES - 1);
    endfunction

endpackage

// File: rtl/lgn_image_buffer.sv
// lgn_image_buffer: one binarized 28x28 image stored as DEPTH bytes.
// Single write port plus one registered read port, shaped so that the
// memory maps onto an iCE40 block RAM.
module lgn_image_buffer
    import lgn_streamer_pkg::*;
#(
    parameter int DEPTH = IMG_BYTES
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    // Host write port; the caller has already range-checked the address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read: data for the address presented in one cycle appears in the next.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/lgn_image_streamer.sv
// lgn_image_streamer: streams a buffered image to the LGN classifier one
// byte per cycle, waits a fixed latency, then captures the predicted class.
// Optional build macro LGN_STREAMER_LOOP_EN: after the first start the image
// is replayed forever, with one class result per pass.
module lgn_image_streamer #(
    parameter int IMG_BYTES      = lgn_streamer_pkg::IMG_BYTES,
    parameter int RESULT_LATENCY = 16,
    parameter int CLASS_W        = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [6:0]         wr_addr,
    input  logic [7:0]         wr_data,
    input  logic               start,
    output logic               busy,
    output logic [7:0]         pix_data,
    output logic               pix_valid,
    output logic               pix_first,
    input  logic [7:0]         dut_result,
    output logic [CLASS_W-1:0] class_out,
    output logic               class_valid,
    output logic               class_err
);

    import lgn_streamer_pkg::*;

    // Latency counter runs 0..RESULT_LATENCY-1 inside WAIT.
    localparam int LAT_W = (RESULT_LATENCY < 2) ? 1 : $clog2(RESULT_LATENCY);

    stream_state_t     state;
    stream_state_t     state_next;
    logic [ADDR_W-1:0] addr_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              last_addr;
    logic              lat_done;
    logic              start_go;
    logic              rd_en;
    logic              capture_en;
    logic              wr_ok;
    logic [7:0]        rd_data;
    logic [3:0]        unused_result_hi;

    assign unused_result_hi = dut_result[7:4];
    assign last_addr        = (addr_cnt == ADDR_W'(IMG_BYTES - 1));
    assign lat_done         = (lat_cnt == LAT_W'(RESULT_LATENCY - 1));

`ifdef LGN_STREAMER_LOOP_EN
    logic running;

    // Once started, the streamer keeps relaunching itself until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
        end else if (state == IDLE && start) begin
            running <= 1'b1;
        end
    end

    assign start_go = start || running;
    assign wr_ok    = wr_en && (wr_addr < ADDR_W'(IMG_BYTES));
`else
    assign start_go = start;
    assign wr_ok    = wr_en && !busy && (wr_addr < ADDR_W'(IMG_BYTES));
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: stream every byte, wait out the classifier, capture.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_go)  state_next = STREAM;
            STREAM:  if (last_addr) state_next = WAIT;
            WAIT:    if (lat_done)  state_next = CAPTURE;
            CAPTURE:                state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // State-decoded controls for the buffer, the result capture and busy.
    always_comb begin
        rd_en      = (state == STREAM);
        capture_en = (state == CAPTURE);
`ifdef LGN_STREAMER_LOOP_EN
        busy       = (state != IDLE) || running;
`else
        busy       = (state != IDLE);
`endif
    end

    // Read address walks the image once per STREAM visit and rests at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt <= '0;
        end else if (state == STREAM && !last_addr) begin
            addr_cnt <= addr_cnt + 1'b1;
        end else begin
            addr_cnt <= '0;
        end
    end

    // Latency counter measures the gap between the last beat and capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt <= '0;
        end else if (state == WAIT && !lat_done) begin
            lat_cnt <= lat_cnt + 1'b1;
        end else begin
            lat_cnt <= '0;
        end
    end

    lgn_image_buffer #(
        .DEPTH   (IMG_BYTES)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (addr_cnt),
        .rd_data (rd_data)
    );

    // Beat flags follow the read request by one cycle, lining up with rd_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_first <= 1'b0;
        end else begin
            pix_valid <= rd_en;
            pix_first <= rd_en && (addr_cnt == '0);
        end
    end

    // The RAM output keeps its last word, so the bus is forced to zero between beats.
    assign pix_data = pix_valid ? rd_data : 8'h00;

    // Result capture: raw class index is kept, out-of-range values are flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            class_out   <= '0;
            class_err   <= 1'b0;
            class_valid <= 1'b0;
        end else begin
            class_valid <= capture_en;
            if (capture_en) begin
                class_out <= CLASS_W'(dut_result[3:0]);
                class_err <= is_bad_class(dut_result[3:0]);
            end
        end
    end

endmodule

// File: tb/tb_lgn_image_streamer.sv
// tb_lgn_image_streamer: scoreboard bench for lgn_image_streamer. Expected
// beats and results are queued when a frame is launched and compared when
// the streamer produces them, including the cycle they appear in.
module tb_lgn_image_streamer;

    import lgn_streamer_pkg::*;

    localparam int LAT    = 16;
    localparam int PERIOD = 100 + LAT;

    typedef struct {
        logic [7:0] data;
        logic       first;
        int         cyc;
    } beat_t;

    typedef struct {
        logic [3:0] cls;
        logic       err;
        int         cyc;
    } res_t;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_first;
    logic [7:0] dut_result;
    logic [3:0] class_out;
    logic       class_valid;
    logic       class_err;

    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         startCyc = 0;
    bit         tbBusy = 0;
    logic [7:0] model [IMG_BYTES];
    beat_t      beatQ[$];
    res_t       resQ[$];

    lgn_image_streamer #(
        .IMG_BYTES      (IMG_BYTES),
        .RESULT_LATENCY (LAT),
        .CLASS_W        (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .busy        (busy),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_first   (pix_first),
        .dut_result  (dut_result),
        .class_out   (class_out),
        .class_valid (class_valid),
        .class_err   (class_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to timestamp expected and observed events.
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeByte(input int addr, input logic [7:0] data);
        bit keep;
`ifdef LGN_STREAMER_LOOP_EN
        keep = (addr < IMG_BYTES);
`else
        keep = (addr < IMG_BYTES) && !tbBusy;
`endif
        wr_en   = 1'b1;
        wr_addr = 7'(addr);
        wr_data = data;
        @(posedge clk);
        if (keep) model[addr] = data;
        #1;
        wr_en = 1'b0;
    endtask

    task automatic pushPass(input int base, input logic [7:0] res);
        beat_t b;
        res_t  r;
        for (int k = 0; k < IMG_BYTES; k++) begin
            b.data  = model[k];
            b.first = (k == 0);
            b.cyc   = base + 1 + k;
            beatQ.push_back(b);
        end
        r.cls = res[3:0];
        r.err = (res[3:0] > 4'd9);
        r.cyc = base + 99 + LAT;
        resQ.push_back(r);
    endtask

    // Launch one frame: start is sampled at the next edge, expectations are queued.
    task automatic applyStimulus(input logic [7:0] res);
        dut_result = res;
        start      = 1'b1;
        @(posedge clk);
        #1;
        startCyc = cyc;
        start    = 1'b0;
        tbBusy   = 1'b1;
        checkOutput("busy_after_start", busy, 1);
        pushPass(startCyc, res);
    endtask

    task automatic waitFrameDone();
        for (int i = 0; i < 400 && resQ.size() != 0; i++) tick();
        checkOutput("frame_drained", beatQ.size() + resQ.size(), 0);
        beatQ.delete();
        resQ.delete();
        tbBusy = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_pix"}, {pix_valid, pix_first, pix_data}, 0);
        checkOutput({tag, "_class"}, {class_valid, class_err, class_out}, 0);
    endtask

    // Monitor: every beat and result is matched against the scoreboard.
    always @(negedge clk) begin : monitor
        beat_t b;
        res_t  r;
        if (!rst) begin
            if (pix_valid) begin
                if (beatQ.size() == 0) begin
                    checkOutput("beat_unexpected", 1, 0);
                end else begin
                    b = beatQ.pop_front();
                    checkOutput("beat_data", pix_data, b.data);
                    checkOutput("beat_first", pix_first, b.first);
                    checkOutput("beat_cycle", cyc, b.cyc);
                end
            end else begin
                checkOutput("idle_bus", {pix_first, pix_data}, 0);
            end
            if (class_valid) begin
                if (resQ.size() == 0) begin
                    checkOutput("class_unexpected", 1, 0);
                end else begin
                    r = resQ.pop_front();
                    checkOutput("class_out", class_out, r.cls);
                    checkOutput("class_err", class_err, r.err);
                    checkOutput("class_cycle", cyc, r.cyc);
`ifdef LGN_STREAMER_LOOP_EN
                    checkOutput("busy_at_result", busy, 1);
`else
                    checkOutput("busy_at_result", busy, 0);
`endif
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        start      = 1'b0;
        dut_result = 8'h00;
        repeat (3) tick();
        checkAllZero("reset");
        rst = 1'b0;
        tick();

        // Frame with one set pixel per byte.
        for (int k = 0; k < IMG_BYTES; k++) writeByte(k, 8'(1 << (k % 8)));

`ifdef LGN_STREAMER_LOOP_EN
        // One start, three passes; byte 0 rewritten during the first pass.
        dut_result = 8'h02;
        start      = 1'b1;
        @(posedge clk);
        #1;
        startCyc = cyc;
        start    = 1'b0;
        tbBusy   = 1'b1;
        pushPass(startCyc, 8'h02);
        repeat (50) tick();
        writeByte(0, 8'h80);
        pushPass(startCyc + PERIOD, 8'h02);
        pushPass(startCyc + 2 * PERIOD, 8'h02);
        while (cyc < startCyc + 3 * PERIOD) tick();
        rst = 1'b1;
        tick();
        checkAllZero("loop_reset");
        rst = 1'b0;
        checkOutput("loop_drained", beatQ.size() + resQ.size(), 0);
        beatQ.delete();
        resQ.delete();
`else
        applyStimulus(8'hF7);
        waitFrameDone();
        repeat (5) tick();
        checkOutput("class_hold", {class_err, class_out}, 5'h07);

        // Random image, out-of-range class, then a valid class again.
        for (int k = 0; k < IMG_BYTES; k++) writeByte(k, 8'($urandom_range(0, 255)));
        applyStimulus(8'hAC);
        waitFrameDone();
        applyStimulus(8'h03);
        waitFrameDone();

        // Dropped writes and ignored start pulses during a frame.
        writeByte(98, 8'h55);
        writeByte(127, 8'h55);
        applyStimulus(8'h59);
        repeat (3) tick();
        writeByte(5, 8'hAA);
        repeat (5) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (50) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (40) tick();
        start = 1'b1; tick(); start = 1'b0;
        waitFrameDone();
        repeat (LAT + 10) tick();

        // Reset during beat 40 aborts the frame without a result.
        applyStimulus(8'h05);
        repeat (41) tick();
        rst = 1'b1;
        tick();
        checkAllZero("abort");
        beatQ.delete();
        resQ.delete();
        tbBusy = 1'b0;
        rst    = 1'b0;
        repeat (150) tick();

        // Buffer survives reset; class 10 is the first out-of-range index.
        applyStimulus(8'h0A);
        waitFrameDone();
`endif

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
